// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between processor writeback and three
// buffered game I/O event sources (button, screen, collision), round-robin.
module regfile_write_arbiter #(
  parameter int MAX_WAIT      = 8,
  parameter int REG_BUTTON    = 20,
  parameter int REG_SCREEN    = 22,
  parameter int REG_COLLISION = 24
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        proc_we,
  input  logic [4:0]  proc_wreg,
  input  logic [31:0] proc_wdata,
  output logic        proc_stall,
  input  logic        button_req,
  input  logic [31:0] button_data,
  input  logic        screen_req,
  input  logic [31:0] screen_data,
  input  logic        collision_req,
  input  logic [31:0] collision_data,
  input  logic        clear_drop,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [2:0]  pending,
  output logic [7:0]  drop_count
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
  localparam logic [4:0] REG_B    = 5'(REG_BUTTON);
  localparam logic [4:0] REG_S    = 5'(REG_SCREEN);
  localparam logic [4:0] REG_C    = 5'(REG_COLLISION);

  logic [2:0]  pend_q;
  logic [31:0] data_q [3];
  logic [1:0]  rr_q;
  logic [7:0]  wait_q;
  logic [7:0]  drop_q;

  logic        stall, proc_sel, ev_sel;
  logic [2:0]  rot, req_vec, gnt_mask, drop_vec;
  logic [1:0]  off, gnt_idx, next_rr, n_drop;
  logic [2:0]  idx_sum;
  logic [8:0]  drop_sum;

  assign req_vec = {collision_req, screen_req, button_req};

  always_comb begin
    stall    = ctrl_reset & (wait_q == WAIT_LIM) & proc_we & (|pend_q);
    proc_sel = ctrl_reset & proc_we & ~stall;
    ev_sel   = ctrl_reset & ~proc_sel & (|pend_q);

    // rotate pending so the rr source sits at bit 0, then find first set
    case (rr_q)
      2'd1:    rot = {pend_q[0], pend_q[2], pend_q[1]};
      2'd2:    rot = {pend_q[1], pend_q[0], pend_q[2]};
      default: rot = pend_q;
    endcase
    off     = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
    idx_sum = {1'b0, rr_q} + {1'b0, off};
    gnt_idx = (idx_sum >= 3'd3) ? 2'(idx_sum - 3'd3) : idx_sum[1:0];
    next_rr = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

    gnt_mask = ev_sel ? (3'b001 << gnt_idx) : 3'b000;
    drop_vec = req_vec & pend_q & ~gnt_mask;
    n_drop   = 2'(drop_vec[0]) + 2'(drop_vec[1]) + 2'(drop_vec[2]);
    drop_sum = {1'b0, drop_q} + {7'b0, n_drop};

    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (proc_sel) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = proc_wreg;
      data_writeReg    = proc_wdata;
    end else if (ev_sel) begin
      ctrl_writeEnable = 1'b1;
      case (gnt_idx)
        2'd1:    begin ctrl_writeReg = REG_S; data_writeReg = data_q[1]; end
        2'd2:    begin ctrl_writeReg = REG_C; data_writeReg = data_q[2]; end
        default: begin ctrl_writeReg = REG_B; data_writeReg = data_q[0]; end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      pend_q    <= 3'b000;
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
      data_q[2] <= 32'd0;
      rr_q      <= 2'd0;
      wait_q    <= 8'd0;
      drop_q    <= 8'd0;
    end else begin
      // a same-cycle grant writes the old value while the new one is captured
      pend_q <= (pend_q & ~gnt_mask) | req_vec;
      if (button_req)    data_q[0] <= button_data;
      if (screen_req)    data_q[1] <= screen_data;
      if (collision_req) data_q[2] <= collision_data;
      if (ev_sel) rr_q <= next_rr;

      if (ev_sel || pend_q == 3'b000) wait_q <= 8'd0;
      else if (wait_q != WAIT_LIM)    wait_q <= wait_q + 8'd1;

      if (clear_drop)          drop_q <= 8'd0;
      else if (drop_sum[8])    drop_q <= 8'hFF;
      else                     drop_q <= drop_sum[7:0];
    end
  end

  assign proc_stall = stall;
  assign pending    = pend_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register file writes are
// queued as stimulus is driven and popped whenever the write port fires.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        proc_we;
  logic [4:0]  proc_wreg;
  logic [31:0] proc_wdata;
  logic        proc_stall;
  logic        button_req, screen_req, collision_req;
  logic [31:0] button_data, screen_data, collision_data;
  logic        clear_drop;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  pending;
  logic [7:0]  drop_count;

  regfile_write_arbiter #(.MAX_WAIT(8)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .proc_we(proc_we), .proc_wreg(proc_wreg), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall),
    .button_req(button_req), .button_data(button_data),
    .screen_req(screen_req), .screen_data(screen_data),
    .collision_req(collision_req), .collision_data(collision_data),
    .clear_drop(clear_drop),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending(pending), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b1;
  logic obs_we, obs_stall;
  logic [4:0]  obs_reg;
  logic [31:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  // one cycle: sample combinational outputs mid-cycle, then cross the edge
  task automatic tick();
    wr_t e;
    @(negedge clock);
    obs_we    = ctrl_writeEnable;
    obs_reg   = ctrl_writeReg;
    obs_data  = data_writeReg;
    obs_stall = proc_stall;
    if (mon_en && obs_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed reg=%0d data=%0h expected=no write", obs_reg, obs_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_reg", 64'(obs_reg), 64'(e.r));
        chk("wr_data", 64'(obs_data), 64'(e.d));
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset = 1'b0; proc_we = 1'b0; proc_wreg = '0; proc_wdata = '0;
    button_req = 1'b0; screen_req = 1'b0; collision_req = 1'b0;
    button_data = '0; screen_data = '0; collision_data = '0; clear_drop = 1'b0;
    @(posedge clock); #1;
    tick(); tick();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_we", 64'(obs_we), 64'd0);
    chk("rst_stall", 64'(obs_stall), 64'd0);
    button_req = 1'b1; button_data = 32'h1;
    tick();
    button_req = 1'b0;
    chk("rst_ignore_req", 64'(pending), 64'd0);
    ctrl_reset = 1'b1;

    // single button event
    button_req = 1'b1; button_data = 32'h5; push(5'd20, 32'h5);
    tick();
    chk("s1_c0_we", 64'(obs_we), 64'd0);
    button_req = 1'b0;
    tick();
    chk("s1_c1_we", 64'(obs_we), 64'd1);
    tick();
    chk("s1_c2_we", 64'(obs_we), 64'd0);
    chk("s1_pending", 64'(pending), 64'd0);
    chk("s1_q_empty", 64'(exp_q.size()), 64'd0);

    // all three at once from a fresh rr pointer
    ctrl_reset = 1'b0; tick(); ctrl_reset = 1'b1;
    button_req = 1'b1; screen_req = 1'b1; collision_req = 1'b1;
    button_data = 32'd1; screen_data = 32'd2; collision_data = 32'd3;
    push(5'd20, 32'd1); push(5'd22, 32'd2); push(5'd24, 32'd3);
    tick();
    button_req = 1'b0; screen_req = 1'b0; collision_req = 1'b0;
    tick(); chk("s2_c1_reg", 64'(obs_reg), 64'd20);
    tick(); chk("s2_c2_reg", 64'(obs_reg), 64'd22);
    tick(); chk("s2_c3_reg", 64'(obs_reg), 64'd24);
    chk("s2_pending", 64'(pending), 64'd0);
    // rr back at button: button must win over screen
    button_req = 1'b1; screen_req = 1'b1; button_data = 32'h11; screen_data = 32'h22;
    push(5'd20, 32'h11); push(5'd22, 32'h22);
    tick();
    button_req = 1'b0; screen_req = 1'b0;
    tick(); tick();
    chk("s2_q_empty", 64'(exp_q.size()), 64'd0);

    // starvation guard
    proc_we = 1'b1; proc_wreg = 5'd5; button_data = 32'h77;
    for (int c = 0; c < 9; c++) begin
      proc_wdata = 32'(100 + c);
      button_req = (c == 0);
      push(5'd5, 32'(100 + c));
      tick();
      chk("s3_nostall", 64'(obs_stall), 64'd0);
    end
    button_req = 1'b0;
    proc_wdata = 32'd109;
    push(5'd20, 32'h77); push(5'd5, 32'd109);
    tick();
    chk("s3_stall", 64'(obs_stall), 64'd1);
    tick();
    chk("s3_held_nostall", 64'(obs_stall), 64'd0);
    chk("s3_held_reg", 64'(obs_reg), 64'd5);
    proc_wreg = 5'd0; proc_wdata = 32'hDEAD; push(5'd0, 32'hDEAD);
    tick();
    proc_we = 1'b0;
    chk("s3_q_empty", 64'(exp_q.size()), 64'd0);

    // overflow while processor busy
    proc_we = 1'b1; proc_wreg = 5'd3;
    proc_wdata = 32'h30; button_req = 1'b1; button_data = 32'hA; push(5'd3, 32'h30);
    tick();
    proc_wdata = 32'h31; button_data = 32'hB; push(5'd3, 32'h31);
    tick();
    chk("s4_drop1", 64'(drop_count), 64'd1);
    proc_we = 1'b0; button_req = 1'b0; push(5'd20, 32'hB);
    tick();
    tick();
    chk("s4_no_rewrite", 64'(obs_we), 64'd0);
    chk("s4_pending", 64'(pending), 64'd0);
    // grant and new request of the same source is not a drop
    button_req = 1'b1; button_data = 32'h1; push(5'd20, 32'h1);
    tick();
    button_data = 32'h2; push(5'd20, 32'h2);
    tick();
    button_req = 1'b0;
    tick();
    chk("s4_same_src_nodrop", 64'(drop_count), 64'd1);
    tick();
    chk("s4_q_empty", 64'(exp_q.size()), 64'd0);

    // reset discards a pending event
    button_req = 1'b1; button_data = 32'h99;
    tick();
    button_req = 1'b0; ctrl_reset = 1'b0;
    tick();
    chk("s5_rst_we", 64'(obs_we), 64'd0);
    ctrl_reset = 1'b1;
    tick();
    chk("s5_pending", 64'(pending), 64'd0);
    chk("s5_drop", 64'(drop_count), 64'd0);
    chk("s5_we", 64'(obs_we), 64'd0);

    // drop_count saturation and clear priority
    mon_en = 1'b0;
    proc_we = 1'b1; proc_wreg = 5'd7; proc_wdata = 32'h0; button_req = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("s6_drop8", 64'(drop_count), 64'd8);
    for (int c = 0; c < 300; c++) tick();
    chk("s6_sat", 64'(drop_count), 64'd255);
    clear_drop = 1'b1;
    tick();
    chk("s6_clear_prio", 64'(drop_count), 64'd0);
    clear_drop = 1'b0;
    tick();
    chk("s6_count_resume", 64'(drop_count), 64'd1);
    button_req = 1'b0; proc_we = 1'b0;
    tick(); tick(); tick();
    exp_q.delete();
    mon_en = 1'b1;
    chk("s6_drained", 64'(pending), 64'd0);
    tick();
    chk("s6_idle_we", 64'(obs_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between processor writeback and three game I/O event sources: button, screen and collision. Event writes target dedicated registers r20, r22 and r24. Each source has a one-deep pending buffer, and pending buffers are served round-robin in cycles the processor does not write. A starvation guard stalls processor writeback after MAX_WAIT lost cycles. Sits between the processor writeback stage / I/O glue and the register file.

Parameters:
MAX_WAIT, 8, consecutive cycles an event may stay pending without a grant before processor writeback is stalled (1..255).
REG_BUTTON, 20, destination register for button events.
REG_SCREEN, 22, destination register for screen events.
REG_COLLISION, 24, destination register for collision events.

Ports:
clock  in  1  system clock, all state updates on rising edge
ctrl_reset  in  1  synchronous, active-low reset
proc_we  in  1  processor writeback request
proc_wreg  in  5  processor destination register
proc_wdata  in  32  processor write data
proc_stall  out  1  processor write not accepted this cycle; processor holds proc_we/wreg/wdata
button_req  in  1  one-cycle button event strobe
button_data  in  32  button value, sampled when button_req=1
screen_req  in  1  screen event strobe
screen_data  in  32  screen value
collision_req  in  1  collision event strobe
collision_data  in  32  collision value
clear_drop  in  1  clears drop_count
ctrl_writeEnable  out  1  register file write enable
ctrl_writeReg  out  5  register file write address
data_writeReg  out  32  register file write data
pending  out  3  pending flags {collision, screen, button}
drop_count  out  8  saturating count of overwritten events

Behaviour:
- Reset (ctrl_reset=0 at edge): pending=0, buffered data=0, rr pointer=0 (button), wait_cnt=0, drop_count=0.
- While ctrl_reset=0: ctrl_writeEnable=0, proc_stall=0, and requests are ignored.
- Write-port outputs are combinational from the current inputs and state; there are no registered outputs besides pending and drop_count.
- Capture: req=1 at edge N sets pending[s] and loads data[s]. The event is visible and grantable from cycle N+1.
- Grant selection:
  - stall = (wait_cnt==MAX_WAIT) & proc_we & |pending.
  - If proc_we & !stall: port = processor write, ctrl_writeEnable=1. proc_wreg=0 is passed through unchanged.
  - Else if |pending: grant the first pending source scanning from rr (order button→screen→collision, cyclic). Port = {REG_x, data[x]}, ctrl_writeEnable=1. At the edge, pending[x] clears and rr = x+1 mod 3.
  - Else: ctrl_writeEnable=0, outputs 0.
- proc_stall=stall. A stalled processor write is not committed and must be re-presented next cycle.
- wait_cnt:
  - Cleared on any event grant or when pending==0.
  - Otherwise incremented each cycle, saturating at MAX_WAIT.
- Simultaneous grant and req of the same source: the old data is written, the new data is captured, and pending stays 1. This is not a drop.
- Overflow: req while pending[s]=1 and s is not granted that cycle → data[s] is overwritten with the newest value, pending stays 1, drop_count+1.
  - drop_count saturates at 255.
  - Multiple simultaneous drops add their count (saturating).
  - clear_drop has priority: drop_count=0 regardless of same-cycle drops.
- A processor write to REG_BUTTON/SCREEN/COLLISION does not affect the pending buffers; the pending event is still committed later.
- Reset mid-operation discards all pending events without writing them.

Test Plan:
- Proc idle; button_req=1, button_data=0x5 at cycle 0 → cycle 1: we=1, reg=20, data=0x5; cycle 2: pending=000, we=0.
- Proc idle; all three reqs at cycle 0 (data 1,2,3) → cycles 1,2,3 write reg20=1, reg22=2, reg24=3; rr returns to button.
- MAX_WAIT=8; proc_we=1 every cycle; button_req at cycle 0 → cycles 1–8 proc writes commit, proc_stall=0. Cycle 9: proc_stall=1 and reg20 is written. Cycle 10: the held proc write commits.
- Proc busy; button_req with 0xA at cycle 0 and 0xB at cycle 1 → drop_count=1, later grant writes reg20=0xB exactly once.
- button_req at cycle 0, ctrl_reset=0 at cycle 1 → no reg20 write; pending=000, drop_count=0 after reset release.
- drop_count preloaded to 255 by 255 drops; another drop → stays 255. clear_drop together with a drop → 0.
